cdb_arbiter: RTL and testbench

- Arbitrates the single common data bus (CDB) among the functional units of the Tomasulo core.
- Each FU holds a completed result {tag, value, op} until it is granted. The block picks one winner per cycle and drives a registered, one-cycle CDB broadcast.
- The broadcast is consumed by the register file, the reservation stations and the dispatcher's JEQ-resolution logic.
- A JEQ result always wins over other results, because the dispatcher stalls fetch until a JEQ resolves. All other results are served round-robin.

---
 rtl/cdb_arbiter_pkg.sv | 24 ++
 rtl/cdb_arbiter_rr_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 93 +++++++++
 tb/tb_cdb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - opcode constants, CDB field widths and pointer helper shared by the CDB arbiter
package cdb_arbiter_pkg;

  // Opcodes as carried in instruction bits [15:12]
  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_ADD = 4'd1,
    OP_LD  = 4'd2,
    OP_LDR = 4'd3,
    OP_JMP = 4'd4,
    OP_JEQ = 4'd5
  } opcode_e;

  // Default CDB field widths
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 16;
  localparam int CDB_OP_W   = 4;

  // Cyclic successor; explicit modulo because the requester count need not be a power of two
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational rotating-priority picker
module cdb_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the start pointer in cyclic order and take the first active request
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_start) + k) % N;
      if (!o_any && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: JEQ override, round-robin pointer, registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int OP_W   = CDB_OP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_v,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_val,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [N_REQ-1:0]        grant,
  output logic                    cdb_v,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_val,
  output logic [OP_W-1:0]         cdb_op
);

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0]  w_jeq_grant;
  logic [PW-1:0]     w_jeq_idx;
  logic              w_jeq_any;
  logic [N_REQ-1:0]  w_rr_grant;
  logic [PW-1:0]     w_rr_idx;
  logic              w_rr_any;
  logic [PW-1:0]     w_sel_idx;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_cdb_v;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_val;
  logic [OP_W-1:0]   r_cdb_op;

  // Pending JEQ results pre-empt round-robin because fetch is stalled on them; lowest index wins
  always_comb begin
    w_jeq_grant = '0;
    w_jeq_idx   = '0;
    w_jeq_any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_jeq_any && req_v[i] && (req_op[i*OP_W +: OP_W] == OP_W'(OP_JEQ))) begin
        w_jeq_grant[i] = 1'b1;
        w_jeq_idx      = PW'(i);
        w_jeq_any      = 1'b1;
      end
    end
  end

  cdb_arbiter_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .i_req   (req_v),
    .i_start (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // A JEQ request is also a valid request, so w_rr_any alone says whether anyone wins
  assign w_sel_idx = w_jeq_any ? w_jeq_idx : w_rr_idx;
  assign grant     = rst ? '0 : (w_jeq_any ? w_jeq_grant : w_rr_grant);

  // Broadcast the winner one cycle later; advance the pointer only on round-robin grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_v   <= 1'b0;
      r_cdb_tag <= '0;
      r_cdb_val <= '0;
      r_cdb_op  <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_cdb_v <= w_rr_any;
      if (w_rr_any) begin
        r_cdb_tag <= req_tag[int'(w_sel_idx)*TAG_W +: TAG_W];
        r_cdb_val <= req_val[int'(w_sel_idx)*DATA_W +: DATA_W];
        r_cdb_op  <= req_op[int'(w_sel_idx)*OP_W +: OP_W];
        if (!w_jeq_any) begin
          r_rr_ptr <= PW'(wrap_inc(int'(w_rr_idx), N_REQ));
        end
      end
    end
  end

  assign cdb_v   = r_cdb_v;
  assign cdb_tag = r_cdb_tag;
  assign cdb_val = r_cdb_val;
  assign cdb_op  = r_cdb_op;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter (N_REQ=4 and N_REQ=3 instances)
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  req_v4;
  logic [15:0] req_tag4;
  logic [63:0] req_val4;
  logic [15:0] req_op4;
  logic [3:0]  grant4;
  logic        cdb_v4;
  logic [3:0]  cdb_tag4;
  logic [15:0] cdb_val4;
  logic [3:0]  cdb_op4;

  logic [2:0]  req_v3;
  logic [11:0] req_tag3;
  logic [47:0] req_val3;
  logic [11:0] req_op3;
  logic [2:0]  grant3;
  logic        cdb_v3;
  logic [3:0]  cdb_tag3;
  logic [15:0] cdb_val3;
  logic [3:0]  cdb_op3;

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(16), .OP_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_v(req_v4), .req_tag(req_tag4), .req_val(req_val4),
    .req_op(req_op4), .grant(grant4), .cdb_v(cdb_v4), .cdb_tag(cdb_tag4),
    .cdb_val(cdb_val4), .cdb_op(cdb_op4)
  );

  cdb_arbiter #(.N_REQ(3), .TAG_W(4), .DATA_W(16), .OP_W(4)) dut3 (
    .clk(clk), .rst(rst), .req_v(req_v3), .req_tag(req_tag3), .req_val(req_val3),
    .req_op(req_op3), .grant(grant3), .cdb_v(cdb_v3), .cdb_tag(cdb_tag3),
    .cdb_val(cdb_val3), .cdb_op(cdb_op3)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] jm;
    logic [3:0] g;
    logic       cv;
    logic [3:0] tag;
    logic [3:0] op;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu4(input int i, input logic [3:0] tag, input logic [15:0] val, input logic [3:0] op);
    req_tag4[i*4 +: 4]  = tag;
    req_val4[i*16 +: 16] = val;
    req_op4[i*4 +: 4]   = op;
  endtask

  // Spec-level reference: lowest valid JEQ first, else first valid from ptr cyclically
  function automatic int model_pick(input logic [3:0] rv, input logic [15:0] ops, input int ptr);
    for (int i = 0; i < 4; i++)
      if (rv[i] && ops[i*4 +: 4] == 4'(OP_JEQ)) return i;
    for (int k = 0; k < 4; k++)
      if (rv[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  initial begin
    int idx;
    int ptr;
    logic [3:0]  etag;
    logic [3:0]  eop;
    logic [15:0] eval;

    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 4'd10, 4'(OP_ADD)};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 4'd11, 4'(OP_ADD)};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 4'd12, 4'(OP_ADD)};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 4'd13, 4'(OP_ADD)};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 4'd10, 4'(OP_ADD)};
    tbl[5]  = '{4'b1110, 4'b1000, 4'b1000, 1'b1, 4'd13, 4'(OP_JEQ)};
    tbl[6]  = '{4'b0110, 4'b1001, 4'b0010, 1'b1, 4'd11, 4'(OP_ADD)};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd11, 4'(OP_ADD)};
    tbl[8]  = '{4'b0011, 4'b0011, 4'b0001, 1'b1, 4'd10, 4'(OP_JEQ)};
    tbl[9]  = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 4'd11, 4'(OP_JEQ)};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 4'd10, 4'(OP_ADD)};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 4'd10, 4'(OP_ADD)};

    rst = 1'b1;
    req_v4 = 4'b1111; req_tag4 = '0; req_val4 = '0; req_op4 = '0;
    req_v3 = '0; req_tag3 = '0; req_val3 = '0; req_op3 = '0;
    for (int i = 0; i < 4; i++) set_fu4(i, 4'(10 + i), 16'hA000 + 16'(i), 4'(OP_ADD));

    // Reset state, with requests pending to show grant is forced low
    #12;
    chk("rst_grant", grant4, 4'b0000);
    chk("rst_cdb_v", cdb_v4, 1'b0);
    chk("rst_cdb_tag", cdb_tag4, 4'd0);
    chk("rst_cdb_val", cdb_val4, 16'd0);
    chk("rst_cdb_op", cdb_op4, 4'd0);
    step();
    rst = 1'b0;

    // Table: round-robin rotation, JEQ override, don't-care inputs, idle, double JEQ
    for (int r = 0; r < 12; r++) begin
      req_v4 = tbl[r].rv;
      for (int i = 0; i < 4; i++)
        set_fu4(i, 4'(10 + i), tbl[r].jm[i] ? 16'h0001 : 16'hA000 + 16'(i),
                tbl[r].jm[i] ? 4'(OP_JEQ) : 4'(OP_ADD));
      #1;
      chk($sformatf("tbl%0d_grant", r), grant4, tbl[r].g);
      step();
      chk($sformatf("tbl%0d_cdb_v", r), cdb_v4, tbl[r].cv);
      chk($sformatf("tbl%0d_cdb_tag", r), cdb_tag4, tbl[r].tag);
      chk($sformatf("tbl%0d_cdb_op", r), cdb_op4, tbl[r].op);
    end

    // Single request, same-cycle grant, one-cycle broadcast
    req_v4 = 4'b0010;
    set_fu4(1, 4'd3, 16'h00AB, 4'(OP_ADD));
    #1;
    chk("single_grant", grant4, 4'b0010);
    step();
    chk("single_cdb_v", cdb_v4, 1'b1);
    chk("single_cdb_tag", cdb_tag4, 4'd3);
    chk("single_cdb_val", cdb_val4, 16'h00AB);
    chk("single_cdb_op", cdb_op4, 4'(OP_ADD));
    req_v4 = 4'b0000;
    step();
    chk("single_cdb_v_drop", cdb_v4, 1'b0);

    // Idle for five cycles: garbage on unused fields, registered fields hold
    for (int c = 0; c < 5; c++) begin
      req_tag4 = 16'($urandom);
      req_val4 = {$urandom, $urandom};
      req_op4  = 16'($urandom);
      #1;
      chk("idle_grant", grant4, 4'b0000);
      step();
      chk("idle_cdb_v", cdb_v4, 1'b0);
      chk("idle_cdb_tag", cdb_tag4, 4'd3);
      chk("idle_cdb_val", cdb_val4, 16'h00AB);
      chk("idle_cdb_op", cdb_op4, 4'(OP_ADD));
    end

    // Reset mid-broadcast: outputs clear without a clock, held request re-served after
    req_v4 = 4'b0100;
    set_fu4(2, 4'd7, 16'h0777, 4'(OP_LD));
    #1;
    chk("rmb_grant", grant4, 4'b0100);
    step();
    chk("rmb_cdb_v_before", cdb_v4, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rmb_cdb_v_async", cdb_v4, 1'b0);
    chk("rmb_cdb_tag_async", cdb_tag4, 4'd0);
    chk("rmb_grant_in_rst", grant4, 4'b0000);
    #2 rst = 1'b0;
    #1;
    chk("rmb_grant_after", grant4, 4'b0100);
    step();
    chk("rmb_cdb_v_after", cdb_v4, 1'b1);
    chk("rmb_cdb_tag_after", cdb_tag4, 4'd7);
    req_v4 = 4'b0000;

    // Pointer wrap on the three-requester instance
    for (int i = 0; i < 3; i++) begin
      req_tag3[i*4 +: 4] = 4'(i + 1);
      req_op3[i*4 +: 4]  = 4'(OP_ADD);
    end
    req_v3 = 3'b100;
    #1;
    chk("n3_grant_fu2", grant3, 3'b100);
    step();
    chk("n3_cdb_tag_fu2", cdb_tag3, 4'd3);
    req_v3 = 3'b011;
    #1;
    chk("n3_grant_wrap", grant3, 3'b001);
    step();
    chk("n3_cdb_tag_wrap", cdb_tag3, 4'd1);
    #1;
    chk("n3_grant_next", grant3, 3'b010);
    step();
    chk("n3_cdb_tag_next", cdb_tag3, 4'd2);
    req_v3 = 3'b000;

    // Randomized traffic against the reference model, from a fresh reset
    rst = 1'b1;
    #2 rst = 1'b0;
    ptr = 0; etag = '0; eop = '0; eval = '0;
    for (int c = 0; c < 300; c++) begin
      req_v4 = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++)
        set_fu4(i, 4'($urandom), 16'($urandom),
                ($urandom_range(0, 5) == 0) ? 4'(OP_JEQ) : 4'($urandom_range(0, 4)));
      idx = model_pick(req_v4, req_op4, ptr);
      #1;
      chk("rand_grant", grant4, (idx < 0) ? 64'd0 : (64'd1 << idx));
      if (idx >= 0) begin
        etag = req_tag4[idx*4 +: 4];
        eval = req_val4[idx*16 +: 16];
        eop  = req_op4[idx*4 +: 4];
        if (eop != 4'(OP_JEQ)) ptr = (idx + 1) % 4;
      end
      step();
      chk("rand_cdb_v", cdb_v4, (idx >= 0) ? 1'b1 : 1'b0);
      chk("rand_cdb_tag", cdb_tag4, etag);
      chk("rand_cdb_val", cdb_val4, eval);
      chk("rand_cdb_op", cdb_op4, eop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
